hb_decim_mc: RTL and testbench
==============================

# hb_decim_mc

Parametrised, multi-channel halfband decimate-by-2 filter. It replaces the fixed single-channel, fully parallel 27-tap halfband stage in the audio decimation chain. Channels arrive time-interleaved on one input bus. One shared pre-add/multiply/accumulate datapath runs serially over the symmetric non-zero coefficient pairs. Outputs are rounded, saturated and channel-tagged, and a bypass mode is provided.

## Interface
- DATA_W, 16: sample width, signed two's complement.
- COEF_W, 16: coefficient width, signed Q(COEF_W-1).
- NTAPS, 27: filter length; must satisfy NTAPS = 4k+3 (elaboration error otherwise).
- NCH, 2: number of interleaved channels; must be at least 1.
- COEF, hb_pkg::HB27_COEF: array of NPAIR+1 coefficients, where NPAIR=(NTAPS+1)/4.
  - Entries 0..NPAIR-1 are h[0],h[2],…,h[NTAPS/2-1].
  - Last entry is the centre tap h[(NTAPS-1)/2].
- clk, in, 1: clock.
- reset_n, in, 1: asynchronous, active-low reset.
- bypass, in, 1: 1 passes each input straight to the output without decimation. Sampled only in IDLE.
- x_in, in, DATA_W: input sample.
- x_in_ch, in, clog2(NCH) (min 1): channel of x_in.
- x_in_valid, in, 1: x_in/x_in_ch are valid.
- x_in_ready, out, 1: block can accept input. A transfer happens when valid && ready.
- y_out, out, DATA_W: output sample.
- y_out_ch, out, clog2(NCH) (min 1): channel of y_out.
- y_out_valid, out, 1: single-cycle strobe; no backpressure.

## Operation
- Each channel has its own NTAPS-deep delay line and its own sample counter n, which saturates at NTAPS+1 and keeps a separate parity bit.
- On each accepted sample of channel c:
  - The sample shifts into the delay line: tap0 is newest, tap NTAPS-1 is oldest.
  - n increments and parity toggles.
- An output is computed when the post-increment count is even (the 2nd, 4th, … sample) and the line holds at least NTAPS samples.
  - Non-output samples and warm-up samples produce no output.
- Accepted samples with x_in_ch ≥ NCH are dropped; no state changes.
- FSM:
  - IDLE: ready=1. On an accept that triggers an output, go to MAC.
  - MAC: NPAIR+1 cycles. Cycle j<NPAIR: acc += COEF[j]·(tap[2j]+tap[NTAPS-1-2j]). Last cycle: acc += COEF[NPAIR]·tap[(NTAPS-1)/2]. Then go to OUT.
  - OUT: round and saturate, pulse y_out_valid, then return to IDLE.
- x_in_ready=0 in MAC and OUT.
- Arithmetic widths:
  - Pre-add: DATA_W+1 bits.
  - Product: DATA_W+COEF_W+1 bits.
  - Accumulator: DATA_W+COEF_W+1+clog2(NPAIR+1) bits, no overflow possible.
- Output scaling: y = sat_DATA_W((acc + 2^(COEF_W-2)) >>> (COEF_W-1)), i.e. round half up, then clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Bypass, latched in IDLE:
  - Every accepted valid-channel sample appears on y_out the next cycle with its channel tag.
  - Delay lines and counters still update.
  - FSM never leaves IDLE; ready stays 1.
- Changing bypass mid-MAC has no effect until IDLE.

## Timing
- Reset values: y_out=0, y_out_ch=0, y_out_valid=0, x_in_ready=0 while reset_n=0; all delay lines, counters, parity and acc are cleared; FSM in IDLE.
- x_in_ready goes to 1 on the first clk edge after reset deasserts.
- Filter latency: accept at edge 0 → y_out_valid high for the cycle after edge NPAIR+2 (NPAIR+1 MAC cycles + OUT). With defaults, the output appears 9 cycles after accept.
- x_in_ready returns to 1 in the same cycle y_out_valid is high, so a back-to-back accept is possible.
- Minimum accept spacing while producing outputs is NPAIR+3 cycles per output-producing sample; non-output samples accept every cycle.
- Bypass latency: 1 cycle.
- Reset asserted mid-MAC: everything clears immediately and no partial output is emitted.

## Structure
- Package hb_pkg holds:
  - The HB27_COEF Q15 array: sum of all taps is 32768, centre tap is 16384.
  - A function that derives NPAIR.
  - The FSM state enum {IDLE, MAC, OUT}.
- Sub-module hb_mac: pre-add, multiply, accumulate with clear/enable, round and saturate. Parameters DATA_W, COEF_W, ACC_W.
- Top level holds the delay lines, counters and FSM.

## Test plan
- Centre tap: defaults, ch0, value 1000 at sample 14 (0-based), zeros otherwise → ch0 output at sample index 27 = 500; output at sample 29 = 0; no output before sample 27.
- Channel independence: NCH=2, ch1 DC 16384, ch0 zeros, interleaved → after warm-up, ch1 outputs settle to 16384 ±1 and ch0 outputs are 0; y_out_ch matches the channel.
- Handshake: x_in_valid held high continuously → ready drops for exactly NPAIR+2 cycles after each output-producing accept; no sample lost (check count of outputs = accepted/2 − warm-up).
- Saturation and rounding: bench COEF with all entries doubled, DC 32767 → y_out=32767; DC −32768 → y_out=−32768.
- Bypass and bad channel: bypass=1, samples 5, −7 on ch1 → identical values on y_out one cycle later. A sample with x_in_ch=NCH produces no output and no state change.
- Reset mid-MAC: assert reset_n=0 during MAC → y_out_valid never pulses for that sample; all outputs read 0; after release, warm-up restarts from n=0.

Source files
------------

// File: rtl/hb_pkg.sv
// Shared definitions for the multi-channel halfband decimator: coefficient set,
// pair-count helper and FSM state encoding.
package hb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } hb_state_e;

  // Number of symmetric non-zero coefficient pairs for an NTAPS = 4k+3 halfband.
  function automatic int hb_npair(input int ntaps);
    return (ntaps + 1) / 4;
  endfunction

  // Q15 halfband: h[0], h[2], ..., h[12], then the centre tap h[13].
  // Pair entries sum to 8192, so the full 27-tap response sums to 32768.
  localparam logic signed [15:0] HB27_COEF [0:7] = '{
    16'sd40, -16'sd120, 16'sd290, -16'sd600,
    16'sd1150, -16'sd2200, 16'sd9632, 16'sd16384
  };

endpackage

// File: rtl/hb_mac.sv
// Serial pre-add / multiply / accumulate datapath.
// Also produces the rounded (half up), saturated output sample.
module hb_mac #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 36
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  input  logic signed [COEF_W-1:0] coef_i,
  output logic signed [DATA_W-1:0] y_o
);

  localparam logic signed [ACC_W-1:0] HALF  = ACC_W'(64'sd1 <<< (COEF_W - 2));
  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

  logic signed [DATA_W:0]        pre_s;
  logic signed [DATA_W+COEF_W:0] prod_s;
  logic signed [ACC_W-1:0]       acc_q, acc_d;
  logic signed [ACC_W-1:0]       rnd_s, shr_s;

  always_comb begin
    pre_s  = {a_i[DATA_W-1], a_i} + {b_i[DATA_W-1], b_i};
    prod_s = pre_s * coef_i;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + ACC_W'(prod_s);
    end else begin
      acc_d = acc_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  always_comb begin
    rnd_s = acc_q + HALF;
    shr_s = rnd_s >>> (COEF_W - 1);
    if (shr_s > Y_MAX) begin
      y_o = Y_MAX[DATA_W-1:0];
    end else if (shr_s < Y_MIN) begin
      y_o = Y_MIN[DATA_W-1:0];
    end else begin
      y_o = shr_s[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/hb_decim_mc.sv
// Multi-channel halfband decimate-by-2 filter with one shared serial MAC.
// Holds per-channel delay lines and sample counters, the control FSM and the output registers.
module hb_decim_mc
  import hb_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int NTAPS  = 27,
  parameter int NCH    = 2,
  parameter logic signed [COEF_W-1:0] COEF [0:hb_npair(NTAPS)] = HB27_COEF,
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     bypass,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic [CH_W-1:0]          x_in_ch,
  input  logic                     x_in_valid,
  output logic                     x_in_ready,
  output logic signed [DATA_W-1:0] y_out,
  output logic [CH_W-1:0]          y_out_ch,
  output logic                     y_out_valid
);

  localparam int NPAIR = hb_npair(NTAPS);
  localparam int CNT_W = $clog2(NPAIR + 1);
  localparam int N_W   = $clog2(NTAPS + 2);
  localparam int ACC_W = DATA_W + COEF_W + 1 + $clog2(NPAIR + 1);
  localparam logic [N_W-1:0]   N_MAX  = N_W'(NTAPS + 1);
  localparam logic [N_W-1:0]   N_FULL = N_W'(NTAPS);
  localparam logic [CNT_W-1:0] J_LAST = CNT_W'(NPAIR);

  if (NTAPS % 4 != 3) begin : g_bad_ntaps
    $error("hb_decim_mc: NTAPS must be of the form 4k+3");
  end
  if (NCH < 1) begin : g_bad_nch
    $error("hb_decim_mc: NCH must be at least 1");
  end

  hb_state_e               state_q, state_d;
  logic [CNT_W-1:0]        j_q, j_d;
  logic [CH_W-1:0]         cur_ch_q, cur_ch_d;
  logic signed [DATA_W-1:0] line_q [NCH][NTAPS];
  logic [N_W-1:0]          n_q [NCH];
  logic [NCH-1:0]          par_q;
  logic                    ready_q, ready_d;
  logic signed [DATA_W-1:0] y_q, y_d;
  logic [CH_W-1:0]         y_ch_q, y_ch_d;
  logic                    y_v_q, y_v_d;

  logic                    ch_ok_s, accept_s, fire_s;
  logic [N_W-1:0]          sel_n_s, n_inc_s;
  logic                    sel_par_s, par_inc_s;
  logic                    mac_clr_s, mac_en_s;
  logic signed [DATA_W-1:0] op_a_s, op_b_s, mac_y_s;
  logic signed [COEF_W-1:0] coef_s;

  // Counter state of the addressed channel and the output decision for this accept.
  always_comb begin
    sel_n_s   = '0;
    sel_par_s = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (c == int'(x_in_ch)) begin
        sel_n_s   = n_q[c];
        sel_par_s = par_q[c];
      end
    end
    ch_ok_s   = int'(x_in_ch) < NCH;
    accept_s  = x_in_valid && ready_q && ch_ok_s;
    n_inc_s   = (sel_n_s == N_MAX) ? N_MAX : sel_n_s + N_W'(1);
    par_inc_s = ~sel_par_s;
    fire_s    = accept_s && !bypass && !par_inc_s && (n_inc_s >= N_FULL);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NCH; c++) begin
        n_q[c] <= '0;
        for (int k = 0; k < NTAPS; k++) begin
          line_q[c][k] <= '0;
        end
      end
      par_q <= '0;
    end else if (accept_s) begin
      for (int c = 0; c < NCH; c++) begin
        if (c == int'(x_in_ch)) begin
          line_q[c][0] <= x_in;
          for (int k = 1; k < NTAPS; k++) begin
            line_q[c][k] <= line_q[c][k-1];
          end
          n_q[c]   <= n_inc_s;
          par_q[c] <= par_inc_s;
        end
      end
    end
  end

  // Pair step j uses taps 2j and NTAPS-1-2j; the final step uses the centre tap alone.
  always_comb begin
    op_a_s = '0;
    op_b_s = '0;
    coef_s = '0;
    for (int c = 0; c < NCH; c++) begin
      if (c == int'(cur_ch_q)) begin
        for (int k = 0; k < NTAPS; k++) begin
          if (j_q == J_LAST) begin
            if (k == (NTAPS - 1) / 2) op_a_s = line_q[c][k];
          end else begin
            if (k == 2 * int'(j_q)) op_a_s = line_q[c][k];
            if (k == NTAPS - 1 - 2 * int'(j_q)) op_b_s = line_q[c][k];
          end
        end
      end
    end
    for (int p = 0; p <= NPAIR; p++) begin
      if (p == int'(j_q)) coef_s = COEF[p];
    end
  end

  hb_mac #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (mac_clr_s),
    .en_i    (mac_en_s),
    .a_i     (op_a_s),
    .b_i     (op_b_s),
    .coef_i  (coef_s),
    .y_o     (mac_y_s)
  );

  always_comb begin
    state_d   = state_q;
    j_d       = j_q;
    cur_ch_d  = cur_ch_q;
    mac_clr_s = 1'b0;
    mac_en_s  = 1'b0;
    y_d       = y_q;
    y_ch_d    = y_ch_q;
    y_v_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (fire_s) begin
          state_d   = MAC;
          j_d       = '0;
          cur_ch_d  = x_in_ch;
          mac_clr_s = 1'b1;
        end else if (accept_s && bypass) begin
          y_d    = x_in;
          y_ch_d = x_in_ch;
          y_v_d  = 1'b1;
        end
      end
      MAC: begin
        mac_en_s = 1'b1;
        if (j_q == J_LAST) begin
          state_d = OUT;
        end else begin
          j_d = j_q + CNT_W'(1);
        end
      end
      OUT: begin
        state_d = IDLE;
        y_d     = mac_y_s;
        y_ch_d  = cur_ch_q;
        y_v_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      j_q      <= '0;
      cur_ch_q <= '0;
      ready_q  <= 1'b0;
      y_q      <= '0;
      y_ch_q   <= '0;
      y_v_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      j_q      <= j_d;
      cur_ch_q <= cur_ch_d;
      ready_q  <= ready_d;
      y_q      <= y_d;
      y_ch_q   <= y_ch_d;
      y_v_q    <= y_v_d;
    end
  end

  assign x_in_ready  = ready_q;
  assign y_out       = y_q;
  assign y_out_ch    = y_ch_q;
  assign y_out_valid = y_v_q;

endmodule

// File: tb/tb_hb_decim_mc.sv
// Directed bench for hb_decim_mc: a default 2-channel instance and a 3-channel
// instance with doubled coefficients (saturation, out-of-range channel).
module tb_hb_decim_mc;
  import hb_pkg::*;

  // Latency in clock edges from the accepting edge to the edge that raises y_out_valid.
  localparam int LAT_FILT = 9;
  localparam int LAT_BYP  = 0;

  // Doubled coefficients; the centre is held at the largest Q15 value.
  localparam logic signed [15:0] SAT_COEF [0:7] = '{
    16'sd80, -16'sd240, 16'sd580, -16'sd1200,
    16'sd2300, -16'sd4400, 16'sd19264, 16'sd32767
  };

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic               a_byp = 1'b0, a_v = 1'b0, a_rdy, a_yv;
  logic signed [15:0] a_x = '0, a_y;
  logic [0:0]         a_ch = '0, a_ych;
  logic               b_byp = 1'b0, b_v = 1'b0, b_rdy, b_yv;
  logic signed [15:0] b_x = '0, b_y;
  logic [1:0]         b_ch = '0, b_ych;

  int nvec = 0;
  int nfail = 0;
  int cyc = 0;
  int ya[$], cha[$], ta[$];
  int yb[$], chb[$], tb[$];

  hb_decim_mc dut (
    .clk(clk), .reset_n(reset_n), .bypass(a_byp),
    .x_in(a_x), .x_in_ch(a_ch), .x_in_valid(a_v), .x_in_ready(a_rdy),
    .y_out(a_y), .y_out_ch(a_ych), .y_out_valid(a_yv)
  );

  hb_decim_mc #(.NCH(3), .COEF(SAT_COEF)) dut_s (
    .clk(clk), .reset_n(reset_n), .bypass(b_byp),
    .x_in(b_x), .x_in_ch(b_ch), .x_in_valid(b_v), .x_in_ready(b_rdy),
    .y_out(b_y), .y_out_ch(b_ych), .y_out_valid(b_yv)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (a_yv === 1'b1) begin
      ya.push_back(int'(a_y)); cha.push_back(int'(a_ych)); ta.push_back(cyc);
    end
    if (b_yv === 1'b1) begin
      yb.push_back(int'(b_y)); chb.push_back(int'(b_ych)); tb.push_back(cyc);
    end
  end

  task automatic clear_obs();
    ya.delete(); cha.delete(); ta.delete();
    yb.delete(); chb.delete(); tb.delete();
  endtask

  // Present one sample, wait for ready, return the edge count of the accepting edge.
  task automatic push(input bit s, input int ch, input int x, output int t);
    int g;
    g = 0;
    @(negedge clk);
    if (!s) begin a_x = 16'(x); a_ch = 1'(ch); a_v = 1'b1; end
    else    begin b_x = 16'(x); b_ch = 2'(ch); b_v = 1'b1; end
    while (((s ? b_rdy : a_rdy) !== 1'b1) && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) begin
      nvec++; nfail++;
      $display("FAIL push_timeout: ready stayed low for %0d cycles, required under 50", g);
    end
    @(negedge clk);
    t = cyc;
    a_v = 1'b0;
    b_v = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; a_v = 1'b0; b_v = 1'b0; a_byp = 1'b0; b_byp = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    clear_obs();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    nvec++; if (a_rdy !== 1'b0) begin nfail++; $display("FAIL rst_ready: got %b want 0", a_rdy); end
    nvec++; if (a_yv !== 1'b0) begin nfail++; $display("FAIL rst_valid: got %b want 0", a_yv); end
    nvec++; if (a_y !== 16'sd0) begin nfail++; $display("FAIL rst_y: got %0d want 0", a_y); end
    nvec++; if (a_ych !== 1'b0) begin nfail++; $display("FAIL rst_ch: got %0d want 0", a_ych); end
    reset_n = 1'b1;
    @(negedge clk);
    nvec++; if (a_rdy !== 1'b1) begin nfail++; $display("FAIL rst_ready_rise: got %b want 1", a_rdy); end
    nvec++; if (b_rdy !== 1'b1) begin nfail++; $display("FAIL rst_ready_rise_s: got %b want 1", b_rdy); end
  endtask

  task automatic test_centre();
    int t, t27;
    t27 = 0;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      push(1'b0, 0, (i == 14) ? 1000 : 0, t);
      if (i == 27) t27 = t;
      if (i == 26) begin
        nvec++;
        if (ya.size() != 0) begin nfail++; $display("FAIL centre_early: got %0d outputs want 0", ya.size()); end
      end
    end
    repeat (12) @(negedge clk);
    nvec++;
    if (ya.size() != 2) begin
      nfail++; $display("FAIL centre_count: got %0d outputs want 2", ya.size());
    end else begin
      nvec++; if (ya[0] != 500) begin nfail++; $display("FAIL centre_y27: got %0d want 500", ya[0]); end
      nvec++; if (cha[0] != 0) begin nfail++; $display("FAIL centre_ch: got %0d want 0", cha[0]); end
      nvec++; if (ta[0] - t27 != LAT_FILT) begin nfail++; $display("FAIL centre_latency: got %0d want %0d", ta[0] - t27, LAT_FILT); end
      nvec++; if (ya[1] != 0) begin nfail++; $display("FAIL centre_y29: got %0d want 0", ya[1]); end
    end
  endtask

  task automatic test_channels();
    int t;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      push(1'b0, 0, 0, t);
      push(1'b0, 1, 16384, t);
    end
    repeat (12) @(negedge clk);
    nvec++;
    if (ya.size() != 4) begin
      nfail++; $display("FAIL chan_count: got %0d outputs want 4", ya.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        nvec++;
        if (cha[k] != k % 2) begin nfail++; $display("FAIL chan_tag[%0d]: got %0d want %0d", k, cha[k], k % 2); end
        nvec++;
        if (ya[k] != ((k % 2) ? 16384 : 0)) begin
          nfail++; $display("FAIL chan_y[%0d]: got %0d want %0d", k, ya[k], (k % 2) ? 16384 : 0);
        end
      end
    end
  endtask

  task automatic test_handshake();
    int acc, run;
    acc = 0; run = 0;
    do_reset();
    a_x = 16'sd100; a_ch = 1'b0; a_v = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if (a_rdy === 1'b1) begin
        if (run != 0) begin
          nvec++;
          if (run != 9) begin nfail++; $display("FAIL hs_ready_low: got %0d cycles want 9", run); end
        end
        run = 0;
        acc++;
      end else begin
        run++;
      end
      @(negedge clk);
    end
    a_v = 1'b0;
    repeat (12) @(negedge clk);
    nvec++;
    if (ya.size() != acc / 2 - 13) begin
      nfail++; $display("FAIL hs_out_count: got %0d want %0d (accepted %0d)", ya.size(), acc / 2 - 13, acc);
    end
    foreach (ya[k]) begin
      nvec++;
      if (ya[k] != 100) begin nfail++; $display("FAIL hs_y[%0d]: got %0d want 100", k, ya[k]); end
    end
  endtask

  task automatic test_saturation();
    int t;
    do_reset();
    for (int i = 0; i < 28; i++) push(1'b1, 0, 32767, t);
    for (int i = 0; i < 28; i++) push(1'b1, 1, -32768, t);
    repeat (12) @(negedge clk);
    nvec++;
    if (yb.size() != 2) begin
      nfail++; $display("FAIL sat_count: got %0d outputs want 2", yb.size());
    end else begin
      nvec++; if (yb[0] != 32767) begin nfail++; $display("FAIL sat_pos: got %0d want 32767", yb[0]); end
      nvec++; if (chb[0] != 0) begin nfail++; $display("FAIL sat_pos_ch: got %0d want 0", chb[0]); end
      nvec++; if (yb[1] != -32768) begin nfail++; $display("FAIL sat_neg: got %0d want -32768", yb[1]); end
      nvec++; if (chb[1] != 1) begin nfail++; $display("FAIL sat_neg_ch: got %0d want 1", chb[1]); end
    end
  endtask

  task automatic test_bypass();
    int t1, t2;
    do_reset();
    a_byp = 1'b1;
    push(1'b0, 1, 5, t1);
    push(1'b0, 1, -7, t2);
    repeat (3) @(negedge clk);
    nvec++; if (a_rdy !== 1'b1) begin nfail++; $display("FAIL byp_ready: got %b want 1", a_rdy); end
    nvec++;
    if (ya.size() != 2) begin
      nfail++; $display("FAIL byp_count: got %0d outputs want 2", ya.size());
    end else begin
      nvec++; if (ya[0] != 5) begin nfail++; $display("FAIL byp_y0: got %0d want 5", ya[0]); end
      nvec++; if (ya[1] != -7) begin nfail++; $display("FAIL byp_y1: got %0d want -7", ya[1]); end
      nvec++; if (cha[1] != 1) begin nfail++; $display("FAIL byp_ch: got %0d want 1", cha[1]); end
      nvec++; if (ta[0] - t1 != LAT_BYP) begin nfail++; $display("FAIL byp_latency: got %0d want %0d", ta[0] - t1, LAT_BYP); end
      nvec++; if (ta[1] - t2 != LAT_BYP) begin nfail++; $display("FAIL byp_latency2: got %0d want %0d", ta[1] - t2, LAT_BYP); end
    end
    a_byp = 1'b0;
  endtask

  task automatic test_bad_channel();
    int t;
    do_reset();
    for (int i = 0; i < 25; i++) push(1'b1, 0, 0, t);
    push(1'b1, 3, 20000, t);
    for (int i = 0; i < 3; i++) push(1'b1, 0, 0, t);
    repeat (12) @(negedge clk);
    nvec++;
    if (yb.size() != 1) begin
      nfail++; $display("FAIL badch_count: got %0d outputs want 1", yb.size());
    end else begin
      nvec++; if (yb[0] != 0) begin nfail++; $display("FAIL badch_y: got %0d want 0", yb[0]); end
      nvec++; if (tb[0] - t != LAT_FILT) begin nfail++; $display("FAIL badch_latency: got %0d want %0d", tb[0] - t, LAT_FILT); end
    end
  endtask

  // Runs after test_bypass, so y_out starts non-zero (-7 on ch1).
  task automatic test_reset_mid_mac();
    int t;
    clear_obs();
    for (int i = 0; i < 28; i++) push(1'b0, 0, 1000, t);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    nvec++; if (a_y !== 16'sd0) begin nfail++; $display("FAIL rmac_y: got %0d want 0", a_y); end
    nvec++; if (a_ych !== 1'b0) begin nfail++; $display("FAIL rmac_ch: got %0d want 0", a_ych); end
    nvec++; if (a_rdy !== 1'b0) begin nfail++; $display("FAIL rmac_ready: got %b want 0", a_rdy); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (15) @(negedge clk);
    nvec++; if (ya.size() != 0) begin nfail++; $display("FAIL rmac_no_out: got %0d outputs want 0", ya.size()); end
    for (int i = 0; i < 27; i++) push(1'b0, 0, 1000, t);
    repeat (12) @(negedge clk);
    nvec++; if (ya.size() != 0) begin nfail++; $display("FAIL rmac_warmup: got %0d outputs want 0", ya.size()); end
    push(1'b0, 0, 1000, t);
    repeat (12) @(negedge clk);
    nvec++;
    if (ya.size() != 1) begin
      nfail++; $display("FAIL rmac_count: got %0d outputs want 1", ya.size());
    end else begin
      nvec++; if (ya[0] != 1000) begin nfail++; $display("FAIL rmac_y_after: got %0d want 1000", ya[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_centre();
    test_channels();
    test_handshake();
    test_saturation();
    test_bypass();
    test_reset_mid_mac();
    test_bad_channel();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
